// File: rtl/pll_pkg.sv
// Shared types and helpers for the multi-channel PLL clock divider:
// sequencer state encoding, channel-select width and config clamp rules.
package pll_pkg;

  typedef enum logic [0:0] {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } pll_state_e;

  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // A zero divide ratio has no meaning; treat it as pass-through (divide by 1).
  function automatic logic [31:0] div_sanitise(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // The start phase must be a reachable count value, i.e. below the ratio.
  function automatic logic [31:0] phase_clamp(input logic [31:0] phase,
                                              input logic [31:0] div);
    return (phase >= div) ? div - 32'd1 : phase;
  endfunction

endpackage

// File: rtl/pll_clkdiv_chan.sv
// One derived-clock channel: divide/phase registers, the phase counter and
// a glitch-free outclk flop fed from the decode of next-state values.
module pll_clkdiv_chan
  import pll_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 run,
  input  logic                 wr,
  input  logic [DIV_WIDTH-1:0] wr_div,
  input  logic [DIV_WIDTH-1:0] wr_phase,
  input  logic                 locked,
  input  logic                 lock_next,
  output logic                 outclk,
  output logic                 outen
);

  logic [DIV_WIDTH-1:0] div, ph, cnt;
  logic [DIV_WIDTH-1:0] div_wr, ph_wr;
  logic [DIV_WIDTH-1:0] div_next, ph_next, cnt_next, hi_next;
  logic                 outclk_next;

  // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
  always_comb begin
    div_wr   = DIV_WIDTH'(div_sanitise(32'(wr_div)));
    ph_wr    = DIV_WIDTH'(phase_clamp(32'(wr_phase), 32'(div_wr)));
    div_next = wr ? div_wr : div;
    ph_next  = wr ? ph_wr  : ph;
    cnt_next = cnt;
    if (load) begin
      cnt_next = ph_next;
    end else if (run) begin
      cnt_next = (cnt >= div - DIV_WIDTH'(1)) ? '0 : cnt + DIV_WIDTH'(1);
    end
    hi_next     = (div_next >> 1) + DIV_WIDTH'(div_next[0]);
    outclk_next = lock_next & (cnt_next < hi_next);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div    <= DIV_WIDTH'(DEFAULT_DIV);
      ph     <= '0;
      cnt    <= '0;
      outclk <= 1'b0;
    end else begin
      div    <= div_next;
      ph     <= ph_next;
      cnt    <= cnt_next;
      outclk <= outclk_next;
    end
  end

  assign outen = locked & (cnt == '0);

endmodule

// File: rtl/pll_clkdiv.sv
// Multi-channel PLL clock divider: lock/relock sequencer, reconfiguration
// handshake and CHANNELS generate-instantiated divider channels.
module pll_clkdiv
  import pll_pkg::*;
#(
  parameter  int CHANNELS    = 2,
  parameter  int DIV_WIDTH   = 8,
  parameter  int LOCK_CYCLES = 16,
  parameter  int DEFAULT_DIV = 1,
  localparam int CHAN_W      = chan_w(CHANNELS)
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  outclk,
  output logic [CHANNELS-1:0]  outen,
  output logic                 locked
);

  localparam logic [0:0] ST_LOCKING = LOCKING;
  localparam logic [0:0] ST_LOCKED  = LOCKED;
  localparam int         LCW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [0:0]          state, state_next;
  logic [LCW-1:0]      lock_cnt, lock_cnt_next;
  logic                accept, lock_done, lock_next, load, run;
  logic [CHANNELS-1:0] wr;

  assign locked    = (state == ST_LOCKED);
  assign cfg_ready = locked;
  assign accept    = cfg_valid & cfg_ready;
  assign lock_done = (lock_cnt == LCW'(LOCK_CYCLES - 1));

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    if (accept) begin
      state_next    = ST_LOCKING;
      lock_cnt_next = '0;
    end else if (state == ST_LOCKING) begin
      state_next    = lock_done ? ST_LOCKED : ST_LOCKING;
      lock_cnt_next = lock_done ? '0 : lock_cnt + LCW'(1);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOCKING;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Every channel reloads its phase on accept and throughout LOCKING, so all
  // channels leave LOCKING on the same edge and stay mutually aligned.
  assign lock_next = (state_next == ST_LOCKED);
  assign load      = (state == ST_LOCKING) | accept;
  assign run       = (state == ST_LOCKED) & ~accept;

  // An out-of-range channel index matches no channel but still forces relock.
  always_comb begin
    wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = accept & (cfg_chan == CHAN_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pll_clkdiv_chan #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .refclk   (refclk),
      .rst      (rst),
      .load     (load),
      .run      (run),
      .wr       (wr[g]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .locked   (locked),
      .lock_next(lock_next),
      .outclk   (outclk[g]),
      .outen    (outen[g])
    );
  end

endmodule

// File: tb/tb_pll_clkdiv.sv
// Self-checking bench for pll_clkdiv: a cycle model pushes expected outputs
// to a scoreboard each edge, plus directed checks of the key waveforms.
module tb_pll_clkdiv;

  // Three channels so that cfg_chan=3 is encodable and out of range.
  localparam int CH = 3;
  localparam int DW = 8;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan  = '0;
  logic [DW-1:0] cfg_div   = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic [CH-1:0] outclk, outen;
  logic          locked;

  int n_tests = 0;
  int n_fail  = 0;

  pll_clkdiv #(
    .CHANNELS   (CH),
    .DIV_WIDTH  (DW),
    .LOCK_CYCLES(LC),
    .DEFAULT_DIV(1)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .outen    (outen),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle model: lock timer counts edges spent unlocked; counters run modulo div.
  bit m_locked;
  int m_lcnt;
  int m_div[CH], m_ph[CH], m_cnt[CH];
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    m_locked = 1'b0;
    m_lcnt   = 0;
    for (int i = 0; i < CH; i++) begin
      m_div[i] = 1; m_ph[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int d;
    if (rst) begin
      model_reset();
    end else if (cfg_valid && m_locked) begin
      if (int'(cfg_chan) < CH) begin
        d = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_div[cfg_chan] = d;
        m_ph[cfg_chan]  = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
      end
      m_locked = 1'b0;
      m_lcnt   = 0;
      for (int i = 0; i < CH; i++) m_cnt[i] = m_ph[i];
    end else if (!m_locked) begin
      m_lcnt++;
      if (m_lcnt == LC) m_locked = 1'b1;
      for (int i = 0; i < CH; i++) m_cnt[i] = m_ph[i];
    end else begin
      for (int i = 0; i < CH; i++) m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
    end
  endfunction

  function automatic logic [7:0] model_expect();
    logic [7:0] e;
    e    = '0;
    e[7] = m_locked;
    e[6] = m_locked;
    for (int i = 0; i < CH; i++) begin
      e[3+i] = m_locked && (m_cnt[i] < (m_div[i] + 1) / 2);
      e[i]   = m_locked && (m_cnt[i] == 0);
    end
    return e;
  endfunction

  function automatic logic [7:0] dut_obs();
    return {locked, cfg_ready, outclk, outen};
  endfunction

  // One clock: model the edge, push the expectation, compare at the falling edge.
  task automatic cycle();
    logic [7:0] exp_v;
    @(posedge refclk);
    model_edge();
    exp_q.push_back(model_expect());
    @(negedge refclk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check("sb", 32'(dut_obs()), 32'(exp_v));
    end
  endtask

  // Holds the request until ready is seen, then lets the accepting edge pass.
  task automatic write(input int ch, input int d, input int p, output int waited);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    waited    = 0;
    while (!cfg_ready && waited < 200) begin
      cycle();
      waited++;
    end
    if (!cfg_ready) check("write_timeout", 32'd0, 32'd1);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(output int lows);
    lows = 0;
    while (!locked && lows < 200) begin
      lows++;
      cycle();
    end
    if (!locked) check("lock_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] cap_c[CH], cap_e[CH];

  task automatic capture(input int n);
    for (int i = 0; i < CH; i++) begin
      cap_c[i] = '0; cap_e[i] = '0;
    end
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < CH; i++) begin
        cap_c[i] = {cap_c[i][30:0], outclk[i]};
        cap_e[i] = {cap_e[i][30:0], outen[i]};
      end
      cycle();
    end
  endtask

  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1 check(tag, 32'(dut_obs()), 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int lows, waited;
    model_reset();
    repeat (2) @(negedge refclk);
    check("reset_state", 32'(dut_obs()), 32'd0);
    rst = 1'b0;

    // Power-up lock, then everything runs at divide-by-1.
    wait_lock(lows);
    check("t1_lock_edges", lows, LC);
    check("t1_ready", 32'(cfg_ready), 32'd1);
    capture(4);
    check("t1_outclk0", cap_c[0], 32'hF);
    check("t1_outclk1", cap_c[1], 32'hF);
    check("t1_outen1", cap_e[1], 32'hF);

    // ch0 divide by 4.
    write(0, 4, 0, waited);
    check("t2_wait", waited, 0);
    wait_lock(lows);
    check("t2_relock", lows, LC);
    capture(8);
    check("t2_outclk0", cap_c[0], 32'b11001100);
    check("t2_outen0", cap_e[0], 32'b10001000);
    check("t2_outclk1", cap_c[1], 32'hFF);

    // ch1 divide by 5, phase 2; ch0 restarts aligned at phase 0.
    write(1, 5, 2, waited);
    wait_lock(lows);
    check("t3_relock", lows, LC);
    capture(10);
    check("t3_outclk1", cap_c[1], 32'b1001110011);
    check("t3_outen1", cap_e[1], 32'b0001000010);
    check("t3_outen0", cap_e[0], 32'b1000100010);

    // div=0 behaves as 1; phase 7 on div 3 clamps to 2.
    write(0, 0, 0, waited);
    wait_lock(lows);
    capture(4);
    check("t4_div0_outclk", cap_c[0], 32'hF);
    check("t4_div0_outen", cap_e[0], 32'hF);
    write(0, 3, 7, waited);
    wait_lock(lows);
    capture(6);
    check("t4_clamp_outclk", cap_c[0], 32'b011011);
    check("t4_clamp_outen", cap_e[0], 32'b010010);

    // Request held through LOCKING is only taken on the first ready edge.
    write(0, 3, 7, waited);
    write(3, 9, 9, waited);
    check("t5_held_wait", waited, LC);
    wait_lock(lows);
    check("t5_relock", lows, LC);
    capture(6);
    check("t5_outclk0", cap_c[0], 32'b011011);
    check("t5_outclk1", cap_c[1], 32'b100111);
    check("t5_outclk2", cap_c[2], 32'h3F);

    // Asynchronous reset while LOCKED, then while LOCKING.
    repeat (3) cycle();
    rst_pulse("t6_rst_locked");
    wait_lock(lows);
    check("t6_relock_a", lows, LC);
    capture(3);
    check("t6_default0", cap_c[0], 32'b111);
    check("t6_default1", cap_c[1], 32'b111);
    write(1, 4, 1, waited);
    repeat (5) cycle();
    rst_pulse("t6_rst_locking");
    wait_lock(lows);
    check("t6_relock_b", lows, LC);
    capture(3);
    check("t6_default1b", cap_c[1], 32'b111);
    check("t6_outen1b", cap_e[1], 32'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
